// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter sharing one SIF XA access port among NUM_REQ masters.
// One transaction in flight; strobe, read-return wait and ack are sequenced.
module sif_xa_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_wr,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [DW-1:0]              req_rdata,
  output logic [AW-1:0]              xa_addr,
  output logic [DW-1:0]              xa_data_wr,
  output logic                       xa_wr_s,
  output logic                       xa_rd_s,
  input  logic [DW-1:0]              xa_data_rd,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 wr_s_q, wr_s_d;
  logic                 rd_s_q, rd_s_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 found;
  logic [IW-1:0]        win;
  int                   idx;

  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_s_d   = 1'b0;
    rd_s_d   = 1'b0;
    ack_d    = '0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ISSUE;
          grant_d  = win;
          wr_d     = req_wr[win];
          addr_d   = req_addr[int'(win)*AW +: AW];
          wdata_d  = req_wdata[int'(win)*DW +: DW];
          wr_s_d   = req_wr[win];
          rd_s_d   = ~req_wr[win];
          rr_ptr_d = IW'((int'(win) + 1) % NUM_REQ);
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d        = ACK;
          rdata_d        = xa_data_rd;
          ack_d[grant_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_s_q   <= 1'b0;
      rd_s_q   <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_s_q   <= wr_s_d;
      rd_s_q   <= rd_s_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ack    = ack_q;
  assign req_rdata  = rdata_q;
  assign xa_addr    = addr_q;
  assign xa_data_wr = wdata_q;
  assign xa_wr_s    = wr_s_q;
  assign xa_rd_s    = rd_s_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Directed bench for sif_xa_arbiter (NUM_REQ=4, RD_LAT=2).
// Inputs change #1 after posedge; outputs are checked at that point too.
module tb_sif_xa_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ack;
  logic [15:0] req_rdata;
  logic [15:0] xa_addr;
  logic [15:0] xa_data_wr;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_data_rd;
  logic        busy;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_err = 0;

  sif_xa_arbiter #(
    .NUM_REQ(4),
    .AW(16),
    .DW(16),
    .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ack(req_ack),
    .req_rdata(req_rdata),
    .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr),
    .xa_wr_s(xa_wr_s),
    .xa_rd_s(xa_rd_s),
    .xa_data_rd(xa_data_rd),
    .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ack"}, 32'(req_ack), 32'h0);
    chk({tag, ".rdata"}, 32'(req_rdata), 32'h0);
    chk({tag, ".addr"}, 32'(xa_addr), 32'h0);
    chk({tag, ".wdata"}, 32'(xa_data_wr), 32'h0);
    chk({tag, ".wr_s"}, 32'(xa_wr_s), 32'h0);
    chk({tag, ".rd_s"}, 32'(xa_rd_s), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".gid"}, 32'(grant_id), 32'h0);
  endtask

  initial begin
    int k;
    int g;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    xa_data_rd = 16'hDEAD;
    #3;
    chk_zero("rst");
    cyc();
    cyc();
    rst_n = 1'b1;

    // T1: R0 write 0x0010 <- 0xBEEF
    req_valid            = 4'b0001;
    req_wr               = 4'b0001;
    req_addr[15:0]       = 16'h0010;
    req_wdata[15:0]      = 16'hBEEF;
    cyc();
    chk("t1.wr_s", 32'(xa_wr_s), 32'h1);
    chk("t1.rd_s", 32'(xa_rd_s), 32'h0);
    chk("t1.addr", 32'(xa_addr), 32'h0010);
    chk("t1.wdata", 32'(xa_data_wr), 32'hBEEF);
    chk("t1.gid", 32'(grant_id), 32'h0);
    chk("t1.busy", 32'(busy), 32'h1);
    chk("t1.ack0", 32'(req_ack), 32'h0);
    req_addr[15:0]  = 16'hFFFF;
    req_wdata[15:0] = 16'h0000;
    cyc();
    chk("t1.ack", 32'(req_ack), 32'h1);
    chk("t1.wr_s_off", 32'(xa_wr_s), 32'h0);
    cyc();
    req_valid = '0;
    chk("t1.idle", 32'(busy), 32'h0);
    chk("t1.ack_off", 32'(req_ack), 32'h0);
    chk("t1.addr_hold", 32'(xa_addr), 32'h0010);
    cyc();

    // T2: R2 read 0x0020, data appears T+3
    req_valid        = 4'b0100;
    req_wr           = 4'b0000;
    req_addr[47:32]  = 16'h0020;
    cyc();
    chk("t2.rd_s", 32'(xa_rd_s), 32'h1);
    chk("t2.wr_s", 32'(xa_wr_s), 32'h0);
    chk("t2.addr", 32'(xa_addr), 32'h0020);
    chk("t2.gid", 32'(grant_id), 32'h2);
    cyc();
    chk("t2.rd_s_off", 32'(xa_rd_s), 32'h0);
    chk("t2.ack_early", 32'(req_ack), 32'h0);
    cyc();
    xa_data_rd = 16'h1234;
    chk("t2.ack_early2", 32'(req_ack), 32'h0);
    cyc();
    xa_data_rd = 16'hDEAD;
    chk("t2.ack", 32'(req_ack), 32'h4);
    chk("t2.rdata", 32'(req_rdata), 32'h1234);
    cyc();
    req_valid = '0;
    chk("t2.ack_off", 32'(req_ack), 32'h0);
    chk("t2.rdata_hold", 32'(req_rdata), 32'h1234);
    cyc();

    // T6: R1 three back-to-back writes (rr_ptr=3, wraps to R1)
    req_valid        = 4'b0010;
    req_wr           = 4'b0010;
    req_addr[31:16]  = 16'h0A00;
    req_wdata[31:16] = 16'h1111;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      k = (c - 1) / 3;
      if (c % 3 == 1) begin
        chk("t6.wr_s", 32'(xa_wr_s), 32'h1);
        chk("t6.addr", 32'(xa_addr), 32'h0A00 + 32'(k));
        chk("t6.wdata", 32'(xa_data_wr), 32'h1111 * 32'(k + 1));
        chk("t6.gid", 32'(grant_id), 32'h1);
        req_addr[31:16]  = 16'(16'h0A00 + k + 1);
        req_wdata[31:16] = 16'(16'h1111 * (k + 2));
      end else if (c % 3 == 2) begin
        chk("t6.ack", 32'(req_ack), 32'h2);
        chk("t6.rdata_hold", 32'(req_rdata), 32'h1234);
        chk("t6.wr_s_off", 32'(xa_wr_s), 32'h0);
      end else begin
        chk("t6.idle", 32'(busy), 32'h0);
        chk("t6.gap_wr_s", 32'(xa_wr_s), 32'h0);
        chk("t6.gap_ack", 32'(req_ack), 32'h0);
      end
    end
    req_valid = '0;
    cyc();

    // T4: rr_ptr=2, R0 and R3 pending -> R3 then R0
    req_valid        = 4'b1001;
    req_wr           = 4'b1001;
    req_addr[63:48]  = 16'h0B03;
    req_addr[15:0]   = 16'h0B00;
    cyc();
    chk("t4.gid_a", 32'(grant_id), 32'h3);
    chk("t4.addr_a", 32'(xa_addr), 32'h0B03);
    cyc();
    chk("t4.ack_a", 32'(req_ack), 32'h8);
    cyc();
    req_valid = 4'b0001;
    chk("t4.idle", 32'(busy), 32'h0);
    cyc();
    chk("t4.gid_b", 32'(grant_id), 32'h0);
    chk("t4.addr_b", 32'(xa_addr), 32'h0B00);
    chk("t4.wr_s_b", 32'(xa_wr_s), 32'h1);
    cyc();
    chk("t4.ack_b", 32'(req_ack), 32'h1);
    cyc();
    req_valid = '0;
    cyc();

    // T3: all four valid continuously from reset
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_wr    = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*16 +: 16]  = 16'(16'h0100 + i);
      req_wdata[i*16 +: 16] = 16'(16'hA000 + i);
    end
    cyc();
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      g = ((c - 1) / 3) % 4;
      chk("t3.rd_s", 32'(xa_rd_s), 32'h0);
      if (c % 3 == 1) begin
        chk("t3.wr_s", 32'(xa_wr_s), 32'h1);
        chk("t3.gid", 32'(grant_id), 32'(g));
        chk("t3.addr", 32'(xa_addr), 32'h0100 + 32'(g));
        chk("t3.wdata", 32'(xa_data_wr), 32'hA000 + 32'(g));
      end else if (c % 3 == 2) begin
        chk("t3.ack", 32'(req_ack), 32'(1 << g));
        chk("t3.wr_s_off", 32'(xa_wr_s), 32'h0);
      end else begin
        chk("t3.gap_ack", 32'(req_ack), 32'h0);
        chk("t3.gid_hold", 32'(grant_id), 32'(g));
      end
    end
    req_valid = '0;
    cyc();

    // T5: reset during read WAIT, then R0 read from rr_ptr=0
    req_valid        = 4'b0100;
    req_wr           = 4'b0000;
    req_addr[47:32]  = 16'h0300;
    cyc();
    chk("t5.rd_s", 32'(xa_rd_s), 32'h1);
    chk("t5.gid", 32'(grant_id), 32'h2);
    cyc();
    chk("t5.wait_busy", 32'(busy), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("t5.arst");
    req_valid      = 4'b0101;
    req_addr[15:0] = 16'h0400;
    cyc();
    chk("t5.noack1", 32'(req_ack), 32'h0);
    cyc();
    chk("t5.noack2", 32'(req_ack), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("t5.gid0", 32'(grant_id), 32'h0);
    chk("t5.rd_s0", 32'(xa_rd_s), 32'h1);
    chk("t5.addr0", 32'(xa_addr), 32'h0400);
    cyc();
    chk("t5.ack_early", 32'(req_ack), 32'h0);
    cyc();
    xa_data_rd = 16'h5A5A;
    cyc();
    xa_data_rd = 16'hDEAD;
    chk("t5.ack", 32'(req_ack), 32'h1);
    chk("t5.rdata", 32'(req_rdata), 32'h5A5A);
    cyc();
    req_valid = '0;
    chk("t5.ack_off", 32'(req_ack), 32'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
